routing_target_resp_tracker: RTL

- Sits in the NI target, at the opposite end of the initiator-side routing LUT.
- For every request header the target NI accepts, it records the initiator ID and transaction tag in an in-order FIFO.
- When the target core answers, it pops the oldest entry and presents a response header: the source-route path back to the initiator, the destination ID and the tag.
- Route encoding is unchanged: first hop in the LSBs, last hop in the MSBs.

---
 rtl/routing_target_resp_tracker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/routing_target_resp_tracker.sv
// Target-side response tracker: queues {initiator ID, tag} per accepted request
// and emits in-order response headers with the source route back to the initiator.
module routing_target_resp_tracker #(
  parameter int DEPTH    = 4,
  parameter int SRC_W    = 4,
  parameter int TAG_W    = 4,
  parameter int PATH_W   = 7,
  parameter int NUM_INIT = 13,
  parameter logic [NUM_INIT*PATH_W-1:0] ROUTE_TABLE = {NUM_INIT{{{(PATH_W-1){1'b0}}, 1'b1}}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_hdr_valid,
  output logic                     req_hdr_ready,
  input  logic [SRC_W-1:0]         req_src_id,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     rsp_hdr_valid,
  input  logic                     rsp_hdr_ready,
  output logic [PATH_W-1:0]        rsp_path,
  output logic [SRC_W-1:0]         rsp_dest,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic                     rsp_route_err,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = SRC_W + TAG_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [EW-1:0]     mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [PATH_W-1:0] path_q, path_d;
  logic [SRC_W-1:0]  dest_q, dest_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;

  logic              push, consume, load, fifo_empty;
  logic [SRC_W-1:0]  head_id;
  logic [TAG_W-1:0]  head_tag;
  logic [PATH_W-1:0] head_path;
  logic              head_err;

  // Ready comes from a register, so a full tracker refuses a push even if a pop coincides.
  assign push       = req_hdr_valid && ready_q;
  assign consume    = valid_q && rsp_hdr_ready;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign load       = !fifo_empty && (!valid_q || rsp_hdr_ready);
  assign {head_id, head_tag} = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    head_path = '0;
    head_err  = 1'b1;
    for (int i = 0; i < NUM_INIT; i++) begin
      if (head_id == SRC_W'(i)) begin
        head_path = ROUTE_TABLE[i*PATH_W +: PATH_W];
        head_err  = 1'b0;
      end
    end
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d      = rd_ptr_q + {{AW{1'b0}}, load};
    outstanding_d = outstanding_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, consume};
    ready_d       = (outstanding_d < DEPTH_C);
    valid_d       = valid_q;
    path_d        = path_q;
    dest_d        = dest_q;
    tag_d         = tag_q;
    err_d         = err_q;
    if (load) begin
      valid_d = 1'b1;
      path_d  = head_path;
      dest_d  = head_id;
      tag_d   = head_tag;
      err_d   = head_err;
    end else if (rsp_hdr_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {req_src_id, req_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      outstanding_q <= '0;
      ready_q       <= 1'b0;
      valid_q       <= 1'b0;
      path_q        <= '0;
      dest_q        <= '0;
      tag_q         <= '0;
      err_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      outstanding_q <= outstanding_d;
      ready_q       <= ready_d;
      valid_q       <= valid_d;
      path_q        <= path_d;
      dest_q        <= dest_d;
      tag_q         <= tag_d;
      err_q         <= err_d;
    end
  end

  assign req_hdr_ready = ready_q;
  assign rsp_hdr_valid = valid_q;
  assign rsp_path      = path_q;
  assign rsp_dest      = dest_q;
  assign rsp_tag       = tag_q;
  assign rsp_route_err = err_q;
  assign outstanding   = outstanding_q;

endmodule
